gerenciador_de_ataque_param: RTL and testbench

GERENCIADOR_DE_ATAQUE_PARAM -- requirements
Module: gerenciador_de_ataque_param

---
 rtl/gerenciador_pkg.sv | 19 +
 rtl/detector_de_borda.sv | 22 ++
 rtl/gerenciador_de_ataque_param.sv | 149 ++++++++++++++
 tb/tb_gerenciador_de_ataque_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/gerenciador_pkg.sv
// Shared types for the naval-battle attack manager: game FSM states and the
// outcome code of the last processed shot.
package gerenciador_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    JOGANDO = 2'd1,
    VITORIA = 2'd2,
    DERROTA = 2'd3
  } estado_t;

  typedef enum logic [1:0] {
    NENHUM   = 2'd0,
    ACERTO   = 2'd1,
    ERRO     = 2'd2,
    REPETIDO = 2'd3
  } resultado_t;

endpackage

// File: rtl/detector_de_borda.sv
// One-bit rising-edge detector: pulses for one cycle when i_sinal goes 0->1.
// The pulse is combinational from the current input so it acts on that same edge.
module detector_de_borda (
  input  logic clock,
  input  logic reset,
  input  logic i_sinal,
  output logic o_pulso
);

  logic r_anterior;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_anterior <= 1'b0;
    end else begin
      r_anterior <= i_sinal;
    end
  end

  assign o_pulso = i_sinal & ~r_anterior;

endmodule

// File: rtl/gerenciador_de_ataque_param.sv
// Attack manager for a COLS x ROWS naval-battle board: classifies each fire
// event as hit, miss or repeated/invalid and tracks lives, hits and game end.
module gerenciador_de_ataque_param
  import gerenciador_pkg::*;
#(
  parameter int COLS  = 5,
  parameter int ROWS  = 7,
  parameter int VIDAS = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             confirmar,
  input  logic [$clog2(COLS)-1:0]          coordColuna,
  input  logic [$clog2(ROWS)-1:0]          coordLinha,
  input  logic [COLS*ROWS-1:0]             mapa,
  output logic [COLS*ROWS-1:0]             matriz,
  output logic                             LED_R,
  output logic                             LED_G,
  output logic                             LED_B,
  output logic [$clog2(VIDAS+1)-1:0]       vida,
  output logic [$clog2(COLS*ROWS+1)-1:0]   acertos,
  output logic                             vitoria,
  output logic                             derrota
);

  localparam int N  = COLS * ROWS;
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int IW = $clog2(N);
  localparam int AW = $clog2(N + 1);
  localparam int VW = $clog2(VIDAS + 1);

  localparam logic [CW:0]   COLS_L  = (CW + 1)'(COLS);
  localparam logic [RW:0]   ROWS_L  = (RW + 1)'(ROWS);
  localparam logic [AW-1:0] N_L     = AW'(N);
  localparam logic [VW-1:0] VIDAS_L = VW'(VIDAS);

  estado_t       r_estado;
  resultado_t    r_resultado;
  logic [N-1:0]  r_tiros;
  logic [N-1:0]  r_matriz;
  logic [AW-1:0] r_acertos;
  logic [VW-1:0] r_vida;
  logic          r_vitoria;
  logic          r_derrota;

  logic          w_limpa;
  logic          w_tiro;
  logic          w_valido;
  logic [IW-1:0] w_idx;
  logic [AW-1:0] w_total;
  logic [AW-1:0] w_acertos_prox;
  resultado_t    w_resultado;

  // enable=0 clears the game exactly like reset, including the fire sample.
  assign w_limpa = reset | ~enable;

  detector_de_borda u_borda (
    .clock   (clock),
    .reset   (w_limpa),
    .i_sinal (confirmar),
    .o_pulso (w_tiro)
  );

  assign w_valido = ({1'b0, coordColuna} < COLS_L) && ({1'b0, coordLinha} < ROWS_L);
  assign w_idx    = IW'(coordColuna) * IW'(ROWS) + IW'(coordLinha);

  // Ships on the board; the map is held stable while a game is running.
  always_comb begin
    w_total = '0;
    for (int i = 0; i < N; i++) begin
      w_total = w_total + AW'(mapa[i]);
    end
  end

  assign w_acertos_prox = (r_acertos == N_L) ? r_acertos : r_acertos + AW'(1);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_resultado = NENHUM;
    if (!w_valido) begin
      w_resultado = REPETIDO;
    end else if (r_tiros[w_idx]) begin
      w_resultado = REPETIDO;
    end else if (mapa[w_idx]) begin
      w_resultado = ACERTO;
    end else begin
      w_resultado = ERRO;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (w_limpa) begin
      // NOTE: the shot-history register is explicitly cleared; a new game must not inherit old shots.
      r_estado    <= OCIOSO;
      r_resultado <= NENHUM;
      r_tiros     <= '0;
      r_matriz    <= '0;
      r_acertos   <= '0;
      r_vida      <= VIDAS_L;
      r_vitoria   <= 1'b0;
      r_derrota   <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: r_estado <= JOGANDO;
        JOGANDO: begin
          if (w_tiro) begin
            r_resultado <= w_resultado;
            case (w_resultado)
              ACERTO: begin
                r_tiros[w_idx]  <= 1'b1;
                r_matriz[w_idx] <= 1'b1;
                r_acertos       <= w_acertos_prox;
                if ((w_acertos_prox == w_total) && (w_total != '0)) begin
                  r_estado  <= VITORIA;
                  r_vitoria <= 1'b1;
                end
              end
              ERRO: begin
                r_tiros[w_idx] <= 1'b1;
                if (r_vida != '0) begin
                  r_vida <= r_vida - VW'(1);
                end
                if (r_vida <= VW'(1)) begin
                  r_estado  <= DERROTA;
                  r_derrota <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        default: ;  // VITORIA and DERROTA hold until cleared
      endcase
    end
  end

  assign matriz  = r_matriz;
  assign acertos = r_acertos;
  assign vida    = r_vida;
  assign vitoria = r_vitoria;
  assign derrota = r_derrota;
  assign LED_R   = (r_resultado == ERRO);
  assign LED_G   = (r_resultado == ACERTO);
  assign LED_B   = (r_resultado == REPETIDO);

endmodule

// File: tb/tb_gerenciador_de_ataque_param.sv
// Directed bench for the attack manager with the default 5x7 board and a
// fixed 8-ship map; expected values are worked out by hand per scenario.
module tb_gerenciador_de_ataque_param;

  localparam logic [34:0] MAPA = {7'b1110000, 7'b0000000, 7'b0000000,
                                  7'b0100000, 7'b1110001};

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        confirmar;
  logic [2:0]  coordColuna;
  logic [2:0]  coordLinha;
  logic [34:0] mapa;
  logic [34:0] matriz;
  logic        LED_R, LED_G, LED_B;
  logic [1:0]  vida;
  logic [5:0]  acertos;
  logic        vitoria, derrota;

  int n_checks = 0;
  int n_errors = 0;

  gerenciador_de_ataque_param dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .confirmar   (confirmar),
    .coordColuna (coordColuna),
    .coordLinha  (coordLinha),
    .mapa        (mapa),
    .matriz      (matriz),
    .LED_R       (LED_R),
    .LED_G       (LED_G),
    .LED_B       (LED_B),
    .vida        (vida),
    .acertos     (acertos),
    .vitoria     (vitoria),
    .derrota     (derrota)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset for two cycles, release, then one edge to reach JOGANDO.
  task automatic restart();
    reset     = 1'b1;
    confirmar = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Returns just after the edge that processes the shot.
  task automatic tiro(input int col, input int lin);
    confirmar = 1'b0;
    tick();
    coordColuna = 3'(col);
    coordLinha  = 3'(lin);
    confirmar   = 1'b1;
    tick();
    confirmar = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    confirmar   = 1'b0;
    coordColuna = '0;
    coordLinha  = '0;
    mapa        = MAPA;
    tick();
    tick();
    check("rst_vida", vida, 3);
    check("rst_acertos", acertos, 0);
    check("rst_matriz", matriz, 0);
    check("rst_leds", {LED_R, LED_G, LED_B}, 0);
    check("rst_fim", {vitoria, derrota}, 0);
    reset = 1'b0;
    tick();

    // Hit then miss
    tiro(0, 0);
    check("a_matriz", matriz, 64'h1);
    check("a_acertos", acertos, 1);
    check("a_leds_hit", {LED_R, LED_G, LED_B}, 3'b010);
    tiro(0, 1);
    check("a_vida_miss", vida, 2);
    check("a_leds_miss", {LED_R, LED_G, LED_B}, 3'b100);

    // Repeated and invalid shots
    tiro(0, 1);
    check("b_rep_leds", {LED_R, LED_G, LED_B}, 3'b001);
    check("b_rep_vida", vida, 2);
    tiro(5, 0);
    check("b_inv_leds", {LED_R, LED_G, LED_B}, 3'b001);
    check("b_inv_vida", vida, 2);
    check("b_inv_matriz", matriz, 64'h1);
    check("b_inv_acertos", acertos, 1);
    tiro(0, 7);
    check("b_inv_row_leds", {LED_R, LED_G, LED_B}, 3'b001);
    tiro(0, 4);
    check("b_hit2_matriz", matriz, 64'h11);
    check("b_hit2_leds", {LED_R, LED_G, LED_B}, 3'b010);

    // Three misses lead to defeat
    restart();
    tiro(1, 0);
    check("c_vida1", vida, 2);
    tiro(2, 0);
    check("c_vida2", vida, 1);
    check("c_no_derrota", derrota, 0);
    tiro(3, 0);
    check("c_vida3", vida, 0);
    check("c_derrota", derrota, 1);
    tiro(0, 0);
    check("c_ign_acertos", acertos, 0);
    check("c_ign_matriz", matriz, 0);
    check("c_ign_leds", {LED_R, LED_G, LED_B}, 3'b100);
    check("c_ign_vida", vida, 0);

    // Sink every ship without a miss
    restart();
    tiro(0, 0); tiro(0, 4); tiro(0, 5); tiro(0, 6);
    tiro(1, 5); tiro(4, 4); tiro(4, 5);
    check("d_vit_before", vitoria, 0);
    check("d_acertos7", acertos, 7);
    tiro(4, 6);
    check("d_vitoria", vitoria, 1);
    check("d_acertos8", acertos, 8);
    check("d_vida", vida, 3);
    check("d_matriz", matriz, {29'd0, MAPA});
    tiro(2, 2);
    check("d_after_vida", vida, 3);
    check("d_after_leds", {LED_R, LED_G, LED_B}, 3'b010);

    // Held fire button and an enable pulse
    restart();
    tiro(0, 0);
    confirmar = 1'b0;
    tick();
    coordColuna = 3'd1;
    coordLinha  = 3'd0;
    confirmar   = 1'b1;
    repeat (10) tick();
    confirmar = 1'b0;
    check("e_held_vida", vida, 2);
    check("e_held_acertos", acertos, 1);
    enable = 1'b0;
    tick();
    check("e_en_vida", vida, 3);
    check("e_en_acertos", acertos, 0);
    check("e_en_matriz", matriz, 0);
    check("e_en_leds", {LED_R, LED_G, LED_B}, 3'b000);
    enable      = 1'b1;
    coordColuna = 3'd0;
    coordLinha  = 3'd0;
    confirmar   = 1'b1;
    tick();
    check("e_ocioso_ign", acertos, 0);
    tiro(0, 0);
    check("e_jogando_hit", acertos, 1);
    check("e_jogando_leds", {LED_R, LED_G, LED_B}, 3'b010);

    // Reset on the same edge as a shot, fire held through release
    confirmar = 1'b0;
    tick();
    coordColuna = 3'd0;
    coordLinha  = 3'd4;
    confirmar   = 1'b1;
    reset       = 1'b1;
    tick();
    check("f_rst_acertos", acertos, 0);
    check("f_rst_matriz", matriz, 0);
    check("f_rst_leds", {LED_R, LED_G, LED_B}, 3'b000);
    reset = 1'b0;
    tick();
    tick();
    check("f_held_acertos", acertos, 0);
    check("f_held_leds", {LED_R, LED_G, LED_B}, 3'b000);
    tiro(0, 4);
    check("f_new_acertos", acertos, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
